// File: rtl/alu_muldiv_pkg.sv
// Shared types for the execute-stage arithmetic units.
//  ALU_Ops : single-cycle ALU operation codes.
//  MD_Ops  : RV32M multiply/divide operation codes (codes 8..15 are unused).
//  MDState : control states of the iterative multiply/divide unit.
//  is_div_op() : true for the four divide/remainder operations.
package alu_muldiv_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } ALU_Ops;

    typedef enum logic [3:0] {
        MulOp    = 4'd0,
        MulhOp   = 4'd1,
        MulhsuOp = 4'd2,
        MulhuOp  = 4'd3,
        DivOp    = 4'd4,
        DivuOp   = 4'd5,
        RemOp    = 4'd6,
        RemuOp   = 4'd7
    } MD_Ops;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } MDState;

    function automatic logic is_div_op(input MD_Ops op);
        logic r;
        case (op)
            DivOp, DivuOp, RemOp, RemuOp: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_muldiv_md_iter_step.sv
// One radix-2 iteration of the multiply/divide core (purely combinational).
//  is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//  hi_i/lo_i: working pair (mul: partial product hi / multiplier lo,
//             div: partial remainder hi / dividend-quotient lo)
//  b_i      : multiplicand (mul) or divisor (div) magnitude
//  hi_o/lo_o: working pair after this iteration
module md_iter_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div_i,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int W = DATA_WIDTH;

    logic [W:0] sum_s;
    logic [W:0] partial_s;
    logic [W:0] diff_s;
    logic       ge_s;

    // Compute both candidate steps and select by operation class.
    always_comb begin
        // Multiply: conditionally add, then shift the {carry,hi,lo} triple right.
        if (lo_i[0]) begin
            sum_s = {1'b0, hi_i} + {1'b0, b_i};
        end else begin
            sum_s = {1'b0, hi_i};
        end
        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // partial < 2*divisor, so bit W of the difference is a clean borrow flag.
        partial_s = {hi_i, lo_i[W-1]};
        diff_s    = partial_s - {1'b0, b_i};
        ge_s      = ~diff_s[W];
        if (is_div_i) begin
            hi_o = ge_s ? diff_s[W-1:0] : partial_s[W-1:0];
            lo_o = {lo_i[W-2:0], ge_s};
        end else begin
            hi_o = sum_s[W:1];
            lo_o = {sum_s[0], lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit, one bit per clock.
//  clk_i, reset_ni : clock, asynchronous active-low reset
//  start_i/ready_o : issue handshake (accepted when ready_o=1)
//  abort_i         : cancel in-flight op, highest priority
//  op_i, a_i, b_i  : operation and operands, captured at accept
//  valid_o         : one-cycle completion pulse
//  result_o        : result, held until the next completion
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  MD_Ops                 op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0]   ONE2     = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};

    MDState           state_q, state_d;
    MD_Ops            op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_neg_q, res_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             special_q, special_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [W-1:0]     result_q, result_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic             a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [W-1:0]     a_mag_s, b_mag_s;
    logic             spec_hit_s;
    logic [W-1:0]     spec_val_s;
    logic [W-1:0]     step_hi_s, step_lo_s;
    logic [2*W-1:0]   prod_fix_s;
    logic [W-1:0]     quot_fix_s, rem_fix_s, fix_res_s;

    md_iter_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div_i (is_div_op(op_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (opb_q),
        .hi_o     (step_hi_s),
        .lo_o     (step_lo_s)
    );

    // Accept-time decode: operand signedness, magnitudes and special-case results.
    always_comb begin
        case (op_i)
            MulhOp:       begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            MulhsuOp:     begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            DivOp, RemOp: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:      begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        a_neg_s = a_signed_s & a_i[W-1];
        b_neg_s = b_signed_s & b_i[W-1];
        a_mag_s = a_neg_s ? (~a_i + ONE) : a_i;
        b_mag_s = b_neg_s ? (~b_i + ONE) : b_i;

        spec_hit_s = 1'b0;
        spec_val_s = '0;
        case (op_i)
            MulOp, MulhOp, MulhsuOp, MulhuOp: begin
                spec_hit_s = 1'b0;
            end
            DivOp, RemOp: begin
                if (b_i == '0) begin
                    spec_hit_s = 1'b1;
                    spec_val_s = (op_i == DivOp) ? '1 : a_i;
                end else if ((a_i == MIN_VAL) && (&b_i)) begin
                    // Signed overflow: quotient saturates to MIN, remainder is zero.
                    spec_hit_s = 1'b1;
                    spec_val_s = (op_i == DivOp) ? MIN_VAL : '0;
                end else begin
                    spec_hit_s = 1'b0;
                end
            end
            DivuOp, RemuOp: begin
                if (b_i == '0) begin
                    spec_hit_s = 1'b1;
                    spec_val_s = (op_i == DivuOp) ? '1 : a_i;
                end else begin
                    spec_hit_s = 1'b0;
                end
            end
            default: begin
                // Unrecognised code: finish quickly with a zero result.
                spec_hit_s = 1'b1;
                spec_val_s = '0;
            end
        endcase
    end

    // Final sign correction and result selection used in FIX.
    always_comb begin
        prod_fix_s = res_neg_q ? (~{hi_q, lo_q} + ONE2) : {hi_q, lo_q};
        quot_fix_s = res_neg_q ? (~lo_q + ONE) : lo_q;
        rem_fix_s  = rem_neg_q ? (~hi_q + ONE) : hi_q;
        case (op_q)
            MulOp:                     fix_res_s = prod_fix_s[W-1:0];
            MulhOp, MulhsuOp, MulhuOp: fix_res_s = prod_fix_s[2*W-1:W];
            DivOp, DivuOp:             fix_res_s = quot_fix_s;
            RemOp, RemuOp:             fix_res_s = rem_fix_s;
            default:                   fix_res_s = '0;
        endcase
        // Special cases park their precomputed result in lo_q.
        if (special_q) begin
            fix_res_s = lo_q;
        end else begin
            fix_res_s = fix_res_s;
        end
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        special_d = special_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        if (abort_i) begin
            // Abort wins over start and over completion; result_o is left alone.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_d      = op_i;
                        res_neg_d = a_neg_s ^ b_neg_s;
                        rem_neg_d = a_neg_s;
                        special_d = spec_hit_s;
                        hi_d      = '0;
                        cnt_d     = CNT_INIT;
                        if (spec_hit_s) begin
                            lo_d    = spec_val_s;
                            opb_d   = '0;
                            state_d = FIX;
                        end else if (is_div_op(op_i)) begin
                            lo_d    = a_mag_s;
                            opb_d   = b_mag_s;
                            state_d = CALC;
                        end else begin
                            lo_d    = b_mag_s;
                            opb_d   = a_mag_s;
                            state_d = CALC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    hi_d = step_hi_s;
                    lo_d = step_lo_s;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = CALC;
                    end
                end
                FIX: begin
                    result_d = fix_res_s;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        ready_d = (state_d == IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            op_q      <= MulOp;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            special_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            special_q <= special_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (DATA_WIDTH=32): directed vectors push their
// hand-computed results into a queue; a monitor pops on every valid_o pulse.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W       = 32;
    localparam int LAT_NRM = W + 1;  // valid_o visible right after edge W+1 (sampled at edge W+2)
    localparam int LAT_SPC = 1;      // valid_o visible right after edge 1 (sampled at edge 2)

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    MD_Ops         op_i = MulOp;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  result_o;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    string         name_q[$];
    logic [W-1:0]  last_res = '0;

    typedef struct {
        MD_Ops        op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
        string        nm;
    } vec_t;
    vec_t vecs[$];

    alu_muldiv #(.DATA_WIDTH(W)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every completion pulse is checked against the oldest expectation.
    always @(negedge clk_i) begin
        if (reset_ni && valid_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got result %h, expected no completion", result_o);
            end else begin
                logic [W-1:0] e;
                string        nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (result_o !== e) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", nm, result_o, e);
                end
            end
        end
    end

    // Issue one op at the current time (#1 after an edge) and wait for completion.
    // Optionally pulses start_i while busy, which must be ignored.
    task automatic run_op(input vec_t v, input bit busy_pulse);
        int k;
        start_i = 1'b1;
        op_i    = v.op;
        a_i     = v.a;
        b_i     = v.b;
        exp_q.push_back(v.exp);
        name_q.push_back(v.nm);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_i     = ~v.a;   // operands were captured; these changes must not matter
        b_i     = v.b ^ 32'h0000_0005;
        op_i    = MulhuOp;
        k = 0;
        while (k < 200) begin
            @(posedge clk_i); #1;
            k++;
            if (busy_pulse && k == 5) start_i = 1'b1;
            if (busy_pulse && k == 6) start_i = 1'b0;
            if (valid_o) break;
        end
        chk({v.nm, "_latency"}, W'(k), W'(v.lat));
        chk({v.nm, "_ready_in_valid"}, W'(ready_o), W'(1));
        last_res = v.exp;
    endtask

    task automatic add(input MD_Ops op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.nm = nm;
        vecs.push_back(v);
    endtask

    initial begin
        add(MulOp,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NRM, "mul_7_m3");
        add(MulhOp,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_NRM, "mulh_min_sq");
        add(MulhuOp,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NRM, "mulhu_max_sq");
        add(MulhsuOp, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NRM, "mulhsu_m1_max");
        add(MulhOp,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, LAT_NRM, "mulh_m2_3");
        add(MulOp,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, LAT_NRM, "mul_shift4");
        add(MulhuOp,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, LAT_NRM, "mulhu_shift4");
        add(DivOp,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_NRM, "div_m7_2");
        add(RemOp,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_NRM, "rem_m7_2");
        add(DivuOp,   32'd100,       32'd7,         32'd14,        LAT_NRM, "divu_100_7");
        add(RemuOp,   32'd100,       32'd7,         32'd2,         LAT_NRM, "remu_100_7");
        add(DivOp,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NRM, "div_7_m2");
        add(RemOp,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT_NRM, "rem_7_m2");
        add(RemOp,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_NRM, "rem_m7_m2");
        add(DivuOp,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, LAT_NRM, "divu_max_16");
        add(RemuOp,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, LAT_NRM, "remu_max_16");
        add(DivOp,    32'h0000_0055, 32'h0000_0000, 32'hFFFF_FFFF, LAT_SPC, "div_by0");
        add(RemuOp,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, LAT_SPC, "remu_by0");
        add(DivuOp,   32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, LAT_SPC, "divu_by0");
        add(RemOp,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, LAT_SPC, "rem_by0");
        add(DivOp,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC, "div_ovf");
        add(RemOp,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPC, "rem_ovf");
        add(MD_Ops'(4'd9), 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, LAT_SPC, "unknown_op");

        // Reset state, asserted asynchronously between edges.
        #1 reset_ni = 1'b0;
        #2;
        chk("reset_ready",  W'(ready_o), W'(1));
        chk("reset_valid",  W'(valid_o), W'(0));
        chk("reset_result", result_o,    '0);
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1'b1;
        @(posedge clk_i); #1;

        // Consecutive ops issue in each other's valid_o cycle (back-to-back).
        foreach (vecs[i]) run_op(vecs[i], (i == 0) || (i == 9));

        // Abort at CALC cycle 10, with a start in the same cycle that must be dropped.
        start_i = 1'b1; op_i = MulOp; a_i = 32'd3; b_i = 32'd5;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; end
        abort_i = 1'b1; start_i = 1'b1; op_i = DivuOp; a_i = 32'd50; b_i = 32'd5;
        @(posedge clk_i); #1;
        abort_i = 1'b0; start_i = 1'b0;
        chk("abort_valid",  W'(valid_o), W'(0));
        chk("abort_ready",  W'(ready_o), W'(1));
        chk("abort_result", result_o,    last_res);
        @(posedge clk_i); #1;
        chk("abort_start_dropped", W'(ready_o), W'(1));
        begin
            vec_t v;
            v.op = MulOp; v.a = 32'd6; v.b = 32'd9; v.exp = 32'd54; v.lat = LAT_NRM; v.nm = "mul_after_abort";
            run_op(v, 1'b0);
        end

        // Asynchronous reset in the middle of CALC: the op is lost without a pulse.
        start_i = 1'b1; op_i = DivuOp; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) begin @(posedge clk_i); #1; end
        #2 reset_ni = 1'b0;
        #1;
        chk("midreset_ready",  W'(ready_o), W'(1));
        chk("midreset_valid",  W'(valid_o), W'(0));
        chk("midreset_result", result_o,    '0);
        @(posedge clk_i); #1 reset_ni = 1'b1;
        @(posedge clk_i); #1;
        begin
            vec_t v;
            v.op = DivuOp; v.a = 32'd1000; v.b = 32'd3; v.exp = 32'd333; v.lat = LAT_NRM; v.nm = "divu_after_reset";
            run_op(v, 1'b0);
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion of the test sequence");
        $fatal(1, "timeout");
    end

endmodule
